// File: rtl/theta_pkg.sv
// theta_pkg: shared FSM states and slice bit indexing for the theta stream engine
package theta_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
  function automatic int bit_idx(input int x, input int y, input int cols);
    return y * cols + x;
  endfunction
endpackage

// File: rtl/keccak_theta_stream_col_parity.sv
// col_parity: column parity of one slice (line: ROWS*COLS slice word in, par: COLS parity bits out)
module col_parity
  import theta_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5
) (
  input  logic [ROWS*COLS-1:0] line,
  output logic [COLS-1:0]      par
);
  always_comb begin
    par = '0;
    for (int x = 0; x < COLS; x++)
      for (int y = 0; y < ROWS; y++)
        par[x] = par[x] ^ line[bit_idx(x, y, COLS)];
  end
endmodule

// File: rtl/keccak_theta_stream.sv
// keccak_theta_stream: slice-serial theta engine; start/busy/done handshake, rd_addr/line_in async read port, wr_en/wr_addr/wr_val write port; THETA_PARITY_TAP_EN adds par_valid/par_out
module keccak_theta_stream
  import theta_pkg::*;
#(
  parameter int SLICES = 64,
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int LINE_W = ROWS * COLS,
  parameter int AW     = $clog2(SLICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     rd_addr,
  input  logic [LINE_W-1:0] line_in,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [LINE_W-1:0] wr_val
`ifdef THETA_PARITY_TAP_EN
  ,
  output logic              par_valid,
  output logic [COLS-1:0]   par_out
`endif
);
  state_t state;
  logic [COLS-1:0] c_prev, c_cur, d;
  logic [LINE_W-1:0] d_line;
  logic [AW-1:0] z;
  col_parity #(.ROWS(ROWS), .COLS(COLS)) u_par (.line(line_in), .par(c_cur));
  // c_prev holds the parity of slice z-1; PRIME loads slice SLICES-1 so z=0 wraps correctly
  always_comb begin
    d = '0;
    for (int x = 0; x < COLS; x++)
      d[x] = c_cur[(x + COLS - 1) % COLS] ^ c_prev[(x + 1) % COLS];
  end
  always_comb begin
    d_line = '0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        d_line[bit_idx(x, y, COLS)] = d[x];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_val  <= '0;
      c_prev  <= '0;
      z       <= '0;
`ifdef THETA_PARITY_TAP_EN
      par_valid <= 1'b0;
      par_out   <= '0;
`endif
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
`ifdef THETA_PARITY_TAP_EN
      par_valid <= 1'b0;
`endif
      case (state)
        IDLE: if (start) begin
          state   <= PRIME;
          busy    <= 1'b1;
          rd_addr <= AW'(SLICES - 1);
        end
        PRIME: begin
          c_prev  <= c_cur;
          z       <= '0;
          rd_addr <= '0;
          state   <= RUN;
        end
        RUN: begin
          wr_en   <= 1'b1;
          wr_addr <= z;
          wr_val  <= line_in ^ d_line;
          c_prev  <= c_cur;
`ifdef THETA_PARITY_TAP_EN
          par_valid <= 1'b1;
          par_out   <= c_cur;
`endif
          if (z == AW'(SLICES - 1)) begin
            state   <= DONE;
            rd_addr <= '0;
          end else begin
            z       <= z + 1'b1;
            rd_addr <= z + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keccak_theta_stream.sv
// tb_keccak_theta_stream: directed checks of the theta stream engine at SLICES=64 and SLICES=8
module tb_keccak_theta_stream;
  localparam int W = 25;
  logic clk = 1'b0, rst = 1'b1, start64 = 1'b0, start8 = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic busy64, done64, wr_en64, busy8, done8, wr_en8;
  logic [5:0] rd64, wa64;
  logic [2:0] rd8, wa8;
  logic [W-1:0] line64, wv64, line8, wv8;
  logic [W-1:0] mem64[64], out64[64], mem8[8], out8[8], exp8[8];
  logic [4:0] c8[8];
  assign line64 = mem64[rd64];
  assign line8  = mem8[rd8];
`ifdef THETA_PARITY_TAP_EN
  logic pv64, pv8;
  logic [4:0] po64, po8;
  logic [4:0] par8[8];
`endif
  keccak_theta_stream #(.SLICES(64)) u_dut64 (
    .clk(clk), .rst(rst), .start(start64), .busy(busy64), .done(done64),
    .rd_addr(rd64), .line_in(line64), .wr_en(wr_en64), .wr_addr(wa64), .wr_val(wv64)
`ifdef THETA_PARITY_TAP_EN
    , .par_valid(pv64), .par_out(po64)
`endif
  );
  keccak_theta_stream #(.SLICES(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .rd_addr(rd8), .line_in(line8), .wr_en(wr_en8), .wr_addr(wa8), .wr_val(wv8)
`ifdef THETA_PARITY_TAP_EN
    , .par_valid(pv8), .par_out(po8)
`endif
  );
  int tot = 0, bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  int base, wr_cnt, first_wr, last_wr, done_cnt, done_rel, rises;
  int rise_at[2];
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    if (wr_en64) begin
      if (wr_cnt == 0) first_wr = cyc - base;
      last_wr = cyc - base;
      out64[wa64] = wv64;
      wr_cnt++;
    end
    if (done64) begin
      done_cnt++;
      done_rel = cyc - base;
    end
    if (busy64 && !busy_q) begin
      if (rises < 2) rise_at[rises] = cyc;
      rises++;
    end
    busy_q = busy64;
  end
  int base8, wr8_cnt = 0, done8_cnt = 0, done8_rel = 0;
  always @(negedge clk) begin
    if (wr_en8) begin
      out8[wa8] = wv8;
      wr8_cnt++;
    end
`ifdef THETA_PARITY_TAP_EN
    if (pv8) par8[wa8] = po8;
`endif
    if (done8) begin
      done8_cnt++;
      done8_rel = cyc - base8;
    end
  end
  task automatic clr64();
    wr_cnt = 0; done_cnt = 0; rises = 0; first_wr = -1; last_wr = -1; done_rel = -1;
    for (int i = 0; i < 64; i++) out64[i] = '1;
  endtask
  task automatic kick64();
    clr64();
    @(negedge clk) start64 = 1'b1;
    @(posedge clk);
    @(negedge clk) base = cyc;
    start64 = 1'b0;
  endtask
  task automatic wait64(input int want);
    for (int n = 0; n < 400 && done_cnt < want; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_seen", 64'(done_cnt >= want), 64'd1);
  endtask
  logic [W-1:0] acc;
  initial begin
    for (int i = 0; i < 64; i++) mem64[i] = '0;
    for (int i = 0; i < 8; i++) mem8[i] = W'($urandom);
    clr64();
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy64), 64'd0);
    check("rst_done", 64'(done64), 64'd0);
    check("rst_wr_en", 64'(wr_en64), 64'd0);
    check("rst_rd_addr", 64'(rd64), 64'd0);
    check("rst_wr_addr", 64'(wa64), 64'd0);
    check("rst_wr_val", 64'(wv64), 64'd0);
    rst = 1'b0;
    kick64(); wait64(1);
    check("zero_wr_cnt", 64'(wr_cnt), 64'd64);
    check("zero_first_wr", 64'(first_wr), 64'd2);
    check("zero_last_wr", 64'(last_wr), 64'd65);
    check("zero_done_edge", 64'(done_rel), 64'd66);
    check("zero_done_cnt", 64'(done_cnt), 64'd1);
    check("zero_busy_after", 64'(busy64), 64'd0);
    acc = '0;
    for (int i = 0; i < 64; i++) acc |= out64[i];
    check("zero_data", 64'(acc), 64'd0);
    mem64[0] = 25'h1;
    kick64(); wait64(1);
    check("s0_slice0", 64'(out64[0]), 64'h0210843);
    check("s0_slice1", 64'(out64[1]), 64'h1084210);
    acc = '0;
    for (int i = 2; i < 64; i++) acc |= out64[i];
    check("s0_rest", 64'(acc), 64'd0);
    mem64[0] = '0; mem64[63] = 25'h1;
    kick64(); wait64(1);
    check("wrap_slice0", 64'(out64[0]), 64'h1084210);
    check("wrap_slice63", 64'(out64[63]), 64'h0210843);
    acc = '0;
    for (int i = 1; i < 63; i++) acc |= out64[i];
    check("wrap_rest", 64'(acc), 64'd0);
    mem64[63] = '0;
    kick64();
    for (int n = 0; n < 100 && wr_cnt < 10; n++) begin
      @(negedge clk);
      #1;
    end
    check("mid_wr_cnt", 64'(wr_cnt), 64'd10);
    rst = 1'b1;
    #1;
    check("mid_wr_en", 64'(wr_en64), 64'd0);
    check("mid_busy", 64'(busy64), 64'd0);
    check("mid_done", 64'(done64), 64'd0);
    #1 rst = 1'b0;
    repeat (80) @(negedge clk);
    check("mid_no_more_wr", 64'(wr_cnt), 64'd10);
    check("mid_no_done", 64'(done_cnt), 64'd0);
    kick64(); wait64(1);
    check("rerun_wr_cnt", 64'(wr_cnt), 64'd64);
    check("rerun_done_edge", 64'(done_rel), 64'd66);
    clr64();
    @(negedge clk) start64 = 1'b1;
    for (int n = 0; n < 400 && rises < 2; n++) @(negedge clk);
    #1 start64 = 1'b0;
    wait64(2);
    check("held_rises", 64'(rises), 64'd2);
    check("held_gap", 64'(rise_at[1] - rise_at[0]), 64'd67);
    check("held_done_cnt", 64'(done_cnt), 64'd2);
    check("held_wr_cnt", 64'(wr_cnt), 64'd128);
    for (int z = 0; z < 8; z++) begin
      c8[z] = '0;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++) c8[z][x] = c8[z][x] ^ mem8[z][y*5+x];
    end
    for (int z = 0; z < 8; z++)
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          exp8[z][y*5+x] = mem8[z][y*5+x] ^ c8[z][(x+4)%5] ^ c8[(z+7)%8][(x+1)%5];
    @(negedge clk) start8 = 1'b1;
    @(posedge clk);
    @(negedge clk) base8 = cyc;
    start8 = 1'b0;
    for (int n = 0; n < 100 && done8_cnt == 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("s8_done_edge", 64'(done8_rel), 64'd10);
    check("s8_wr_cnt", 64'(wr8_cnt), 64'd8);
    for (int z = 0; z < 8; z++) check($sformatf("s8_slice%0d", z), 64'(out8[z]), 64'(exp8[z]));
`ifdef THETA_PARITY_TAP_EN
    for (int z = 0; z < 8; z++) check($sformatf("s8_par%0d", z), 64'(par8[z]), 64'(c8[z]));
`endif
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule

// File: doc/keccak_theta_stream.md
# keccak_theta_stream

Slice-serial Keccak θ (column-parity diffusion) engine, the parametrised successor to the fixed 25-bit/64-slice column-parity function. It streams a ROWS×COLS×SLICES state one slice per cycle from an external state memory and writes the θ-transformed slices back. It handles the z-1 wrap-around with a priming read and generalises the lane count and slice geometry. It sits between the state memory and the round controller of the matrix encoder.

## Interface
- SLICES, 64, number of slices (lane length); ≥2, any integer
- ROWS, 5, rows per slice
- COLS, 5, columns per slice; ≥3
- LINE_W, ROWS*COLS, derived slice word width; bit index = y*COLS + x
- AW, $clog2(SLICES), derived address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin transform; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- rd_addr  out  AW  slice being read (registered)
- line_in  in  LINE_W  slice word at rd_addr, same cycle (asynchronous memory read)
- wr_en  out  1  write strobe (registered)
- wr_addr  out  AW  slice index being written
- wr_val  out  LINE_W  θ-transformed slice

## Operation
- C[x][z] = XOR over y of A[x][y][z]; D[x][z] = C[(x-1) mod COLS][z] ^ C[(x+1) mod COLS][(z-1) mod SLICES]; A'[x][y][z] = A ^ D[x][z].
- FSM IDLE -> PRIME -> RUN -> DONE -> IDLE.
- IDLE: rd_addr=0, busy=0. start=1 -> PRIME.
- PRIME (1 cycle): rd_addr=SLICES-1. Register the column parity of that slice into c_prev. -> RUN with z=0.
- RUN (SLICES cycles): rd_addr=z. Compute c_cur from line_in. Register wr_en=1, wr_addr=z, wr_val=line_in ^ D. Update c_prev<=c_cur. z==SLICES-1 -> DONE, else z+1.
- DONE (1 cycle): done=1 registered. -> IDLE.
- start while not IDLE is ignored. start held high through DONE does not retrigger until IDLE samples it.
- Reset values: busy, done, wr_en = 0; rd_addr, wr_addr, wr_val, c_prev, z = 0; state IDLE.
- Reset mid-operation clears everything immediately. No further wr_en or done is produced, and memory contents are left partially written. Recovery requires a fresh start.
- Arithmetic is pure XOR, with no width growth. Column indices use mod COLS and slice indices use mod SLICES. The wrap is handled solely by PRIME, with no second pass.

## Timing
- Start accepted on edge e0. PRIME runs in cycle e0–e1, and RUN slice z in cycle e(z+1)–e(z+2).
- wr_en is high for SLICES consecutive cycles, from edge e2 through edge e(SLICES+1). Slice z is written in the cycle after it is read.
- done rises on edge e(SLICES+2) for exactly one cycle, which is the cycle after the last wr_en. busy falls on the same edge.
- The earliest next accepted start is the edge after done, giving a throughput of SLICES+3 cycles per transform.
- rd_addr never equals a same-cycle wr_addr except in PRIME-free overlap. Memory must support a read of z concurrent with a write of z-1.

## Configuration
- THETA_PARITY_TAP_EN defined: adds ports par_valid (out, 1) and par_out (out, COLS). These are registered and mirror wr_en timing. par_out carries C[·][z] for the slice being written, for use by a downstream checker. Reset value is 0.
- THETA_PARITY_TAP_EN undefined: these ports and registers do not exist, and the datapath behaviour is otherwise identical.

## Structure
- Shared package theta_pkg holds the FSM state enum (IDLE, PRIME, RUN, DONE) and the bit_idx(x,y) index function.
- Sub-module col_parity (combinational, parameters ROWS/COLS) maps a LINE_W slice to a COLS-bit parity. It is instantiated once, on line_in.

## Test plan
- All-zero memory, SLICES=64 -> 64 writes of 25'h0; wr_en on edges 2..65; done single pulse at edge 66.
- Slice 0 = 25'h1 (x0,y0), others zero -> slice 0 written 25'h0210843, slice 1 written 25'h1084210, all other slices 25'h0.
- Wrap: slice 63 = 25'h1, others zero -> slice 0 written 25'h1084210, slice 63 written 25'h0210843.
- rst pulsed during the 10th wr_en -> wr_en low at once, no done, busy=0. A new start then gives a full 64-write run and done.
- start held high continuously across two runs -> second run begins only after IDLE, exactly SLICES+3 cycles apart. No start is accepted mid-run.
- SLICES=8 with random state -> output matches reference θ model, done at edge 10. With THETA_PARITY_TAP_EN defined, par_out equals the model C[·][z] on each wr_en.
